// File: rtl/video_mono_filter_pkg.sv
// Shared types and constants for the video_mono_filter block: mode enum,
// luma weights, pixel widths, plus the tint mapping and dimming helpers.
package video_pkg;

  localparam int PIX_W      = 6;
  localparam int LUMA_ACC_W = 12;
  localparam int LUMA_WR    = 13;
  localparam int LUMA_WG    = 46;
  localparam int LUMA_WB    = 5;
  localparam int LUMA_SHIFT = 6;

  typedef enum logic [1:0] {
    MODE_COLOR = 2'b00,
    MODE_GREEN = 2'b01,
    MODE_AMBER = 2'b10,
    MODE_BW    = 2'b11
  } mode_e;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    pix_t r;
    pix_t g;
    pix_t b;
  } rgb_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic hb;
    logic vb;
  } tim_t;

  function automatic rgb_t mono_map(
    input mode_e m,
    input rgb_t  raw,
    input pix_t  y
  );
    rgb_t o;
    o = raw;
    unique case (m)
      MODE_COLOR: o = raw;
      MODE_GREEN: o = '{r: '0, g: y, b: '0};
      MODE_AMBER: o = '{r: y, g: y >> 1, b: '0};
      MODE_BW:    o = '{r: y, g: y, b: y};
    endcase
    return o;
  endfunction

  // 75% intensity, used for dark scanlines.
  function automatic pix_t dim(input pix_t v);
    return v - (v >> 2);
  endfunction

endpackage

// File: rtl/video_mono_filter_if.sv
// Pixel/timing bundle between the video source and video_mono_filter.
// master: source side (drives *_in, mode_in, ce_pix); slave: the filter.
interface video_mono_filter_if;
  import video_pkg::*;

  logic       ce_pix;
  pix_t       r_in;
  pix_t       g_in;
  pix_t       b_in;
  logic       hsync_in;
  logic       vsync_in;
  logic       hblank_in;
  logic       vblank_in;
  logic [1:0] mode_in;

  pix_t       r_out;
  pix_t       g_out;
  pix_t       b_out;
  logic       hsync_out;
  logic       vsync_out;
  logic       hblank_out;
  logic       vblank_out;
  logic [1:0] mode_active;

  modport master (
    output ce_pix, r_in, g_in, b_in,
    output hsync_in, vsync_in, hblank_in, vblank_in,
    output mode_in,
    input  r_out, g_out, b_out,
    input  hsync_out, vsync_out, hblank_out, vblank_out,
    input  mode_active
  );

  modport slave (
    input  ce_pix, r_in, g_in, b_in,
    input  hsync_in, vsync_in, hblank_in, vblank_in,
    input  mode_in,
    output r_out, g_out, b_out,
    output hsync_out, vsync_out, hblank_out, vblank_out,
    output mode_active
  );

endinterface

// File: rtl/video_mono_filter_luma.sv
// video_luma: two-stage weighted RGB->Y (S1 products, S2 sum and shift).
// Ports: clk, reset (sync, high), ce_pix, r/g/b in; y out (2 enabled cycles).
module video_luma
  import video_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ce_pix,
  input  pix_t r,
  input  pix_t g,
  input  pix_t b,
  output pix_t y
);

  logic [LUMA_ACC_W-1:0] pr;
  logic [LUMA_ACC_W-1:0] pg;
  logic [LUMA_ACC_W-1:0] pb;
  logic [LUMA_ACC_W-1:0] sum;

  // Weights sum to 64, so 63*64 fits in 12 bits with no carry out.
  assign sum = pr + pg + pb;

  always_ff @(posedge clk) begin
    if (reset) begin
      pr <= '0;
      pg <= '0;
      pb <= '0;
      y  <= '0;
    end else if (ce_pix) begin
      pr <= LUMA_ACC_W'(r) * LUMA_ACC_W'(LUMA_WR);
      pg <= LUMA_ACC_W'(g) * LUMA_ACC_W'(LUMA_WG);
      pb <= LUMA_ACC_W'(b) * LUMA_ACC_W'(LUMA_WB);
      y  <= PIX_W'(sum >> LUMA_SHIFT);
    end
  end

endmodule

// File: rtl/video_mono_filter.sv
// Monochrome tint filter: luma, mode mapping, 3-cycle aligned timing.
// Ports: clk, reset (sync, high), vif (slave). Macro VIDEO_MONO_SCANLINE_EN.
module video_mono_filter
  import video_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  video_mono_filter_if.slave  vif
);

  rgb_t  raw_s1;
  rgb_t  raw_s2;
  tim_t  tim_s1;
  tim_t  tim_s2;
  tim_t  tim_s3;
  pix_t  y_s2;
  rgb_t  map_s2;
  rgb_t  s3_d;
  rgb_t  out_q;
  mode_e mode_q;
  logic  vb_d;

  video_luma u_luma (
    .clk    (clk),
    .reset  (reset),
    .ce_pix (vif.ce_pix),
    .r      (vif.r_in),
    .g      (vif.g_in),
    .b      (vif.b_in),
    .y      (y_s2)
  );

`ifdef VIDEO_MONO_SCANLINE_EN
  logic par;
  logic par_s1;
  logic par_s2;
  logic hs_d;
  logic vs_d;

  // Each pixel carries the parity in force when it entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      par    <= 1'b0;
      par_s1 <= 1'b0;
      par_s2 <= 1'b0;
      hs_d   <= 1'b0;
      vs_d   <= 1'b0;
    end else if (vif.ce_pix) begin
      hs_d   <= vif.hsync_in;
      vs_d   <= vif.vsync_in;
      par_s1 <= par;
      par_s2 <= par_s1;
      if (vif.vsync_in && !vs_d)
        par <= 1'b0;
      else if (vif.hsync_in && !hs_d)
        par <= ~par;
    end
  end
`endif

  always_comb begin
    map_s2 = mono_map(mode_q, raw_s2, y_s2);
    s3_d   = map_s2;
`ifdef VIDEO_MONO_SCANLINE_EN
    if (par_s2 && !tim_s2.hb && !tim_s2.vb) begin
      s3_d.r = dim(map_s2.r);
      s3_d.g = dim(map_s2.g);
      s3_d.b = dim(map_s2.b);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_s1 <= '0;
      raw_s2 <= '0;
      tim_s1 <= '0;
      tim_s2 <= '0;
      tim_s3 <= '0;
      out_q  <= '0;
      vb_d   <= 1'b0;
      mode_q <= MODE_COLOR;
    end else if (vif.ce_pix) begin
      raw_s1 <= '{r: vif.r_in, g: vif.g_in, b: vif.b_in};
      tim_s1 <= '{hs: vif.hsync_in, vs: vif.vsync_in,
                  hb: vif.hblank_in, vb: vif.vblank_in};
      raw_s2 <= raw_s1;
      tim_s2 <= tim_s1;
      tim_s3 <= tim_s2;
      out_q  <= s3_d;
      vb_d   <= vif.vblank_in;
      // Only a vblank rise swaps modes, so frames never mix tints.
      if (vif.vblank_in && !vb_d)
        mode_q <= mode_e'(vif.mode_in);
    end
  end

  assign vif.r_out       = out_q.r;
  assign vif.g_out       = out_q.g;
  assign vif.b_out       = out_q.b;
  assign vif.hsync_out   = tim_s3.hs;
  assign vif.vsync_out   = tim_s3.vs;
  assign vif.hblank_out  = tim_s3.hb;
  assign vif.vblank_out  = tim_s3.vb;
  assign vif.mode_active = mode_q;

endmodule

// File: tb/tb_video_mono_filter.sv
// Directed bench for video_mono_filter with a 3-deep scoreboard model.
// Scanline cases run only when VIDEO_MONO_SCANLINE_EN is defined.
module tb_video_mono_filter;

  typedef struct {
    logic [5:0] r, g, b;
    logic hs, vs, hb, vb, par;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  video_mono_filter_if vif ();

  video_mono_filter dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );

  int n_err = 0;
  int n_chk = 0;
  ent_t sb[$];

  logic [1:0] m_mode;
  logic m_vbd, m_hsd, m_vsd, m_par;
  logic [5:0] e_r, e_g, e_b;
  logic e_hs, e_vs, e_hb, e_vb;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] luma(input ent_t e);
    int s;
    s = 13 * int'(e.r) + 46 * int'(e.g) + 5 * int'(e.b);
    return 6'(s / 64);
  endfunction

  function automatic logic [5:0] dm(input logic [5:0] v, input logic on);
    int t;
    t = int'(v);
    if (on) t = t - t / 4;
    return 6'(t);
  endfunction

  task automatic expect_of(input ent_t e, input logic [1:0] md);
    logic [5:0] y;
    logic on;
    y = luma(e);
    case (md)
      2'd0: begin e_r = e.r; e_g = e.g; e_b = e.b; end
      2'd1: begin e_r = 0; e_g = y; e_b = 0; end
      2'd2: begin e_r = y; e_g = 6'(int'(y) / 2); e_b = 0; end
      default: begin e_r = y; e_g = y; e_b = y; end
    endcase
    on = 1'b0;
`ifdef VIDEO_MONO_SCANLINE_EN
    on = e.par && !e.hb && !e.vb;
`endif
    e_r = dm(e_r, on);
    e_g = dm(e_g, on);
    e_b = dm(e_b, on);
    e_hs = e.hs; e_vs = e.vs; e_hb = e.hb; e_vb = e.vb;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".r"}, 8'(vif.r_out), 8'(e_r));
    chk({tag, ".g"}, 8'(vif.g_out), 8'(e_g));
    chk({tag, ".b"}, 8'(vif.b_out), 8'(e_b));
    chk({tag, ".hs"}, 8'(vif.hsync_out), 8'(e_hs));
    chk({tag, ".vs"}, 8'(vif.vsync_out), 8'(e_vs));
    chk({tag, ".hb"}, 8'(vif.hblank_out), 8'(e_hb));
    chk({tag, ".vb"}, 8'(vif.vblank_out), 8'(e_vb));
    chk({tag, ".mode"}, 8'(vif.mode_active), 8'(m_mode));
  endtask

  task automatic model_clear();
    ent_t z;
    z = '{default: 1'b0};
    sb.delete();
    sb.push_back(z);
    sb.push_back(z);
    m_mode = 0; m_vbd = 0; m_hsd = 0; m_vsd = 0; m_par = 0;
    e_r = 0; e_g = 0; e_b = 0;
    e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0;
  endtask

  task automatic step(input string tag, input logic [5:0] r, g, b,
                      input logic hs, vs, hb, vb,
                      input logic [1:0] md, input logic ce);
    ent_t e, o;
    logic [1:0] used;
    vif.r_in = r; vif.g_in = g; vif.b_in = b;
    vif.hsync_in = hs; vif.vsync_in = vs;
    vif.hblank_in = hb; vif.vblank_in = vb;
    vif.mode_in = md; vif.ce_pix = ce;
    used = m_mode;
    if (ce) begin
      e = '{r: r, g: g, b: b, hs: hs, vs: vs, hb: hb, vb: vb, par: m_par};
      sb.push_back(e);
      if (vs && !m_vsd) m_par = 1'b0;
      else if (hs && !m_hsd) m_par = ~m_par;
      m_hsd = hs; m_vsd = vs;
      if (vb && !m_vbd) m_mode = md;
      m_vbd = vb;
    end
    @(posedge clk);
    #1;
    if (ce) begin
      if (sb.size() == 0) begin
        n_chk++; n_err++;
        $error("FAIL %s scoreboard empty got=0 want=1", tag);
      end else begin
        o = sb.pop_front();
        expect_of(o, used);
      end
    end
    compare_all(tag);
  endtask

  task automatic px(input string tag, input logic [5:0] r, g, b,
                    input logic [1:0] md);
    step(tag, r, g, b, 0, 0, 0, 0, md, 1);
  endtask

  task automatic flush(input string tag, input logic [1:0] md);
    for (int i = 0; i < 3; i++) px(tag, 0, 0, 0, md);
  endtask

  task automatic set_mode(input logic [1:0] md);
    step("vb_lo", 0, 0, 0, 0, 0, 0, 0, md, 1);
    step("vb_rise", 0, 0, 0, 0, 0, 0, 1, md, 1);
    step("vb_hold", 0, 0, 0, 0, 0, 0, 1, md, 1);
    flush("settle", md);
  endtask

  task automatic do_reset(input logic vb, input logic [1:0] md);
    reset = 1'b1;
    vif.r_in = 6'd33; vif.g_in = 6'd44; vif.b_in = 6'd55;
    vif.hsync_in = 1; vif.vsync_in = 0;
    vif.hblank_in = 0; vif.vblank_in = vb;
    vif.mode_in = md; vif.ce_pix = 1;
    @(posedge clk);
    #1;
    model_clear();
    compare_all("reset");
    reset = 1'b0;
  endtask

  initial begin
    vif.ce_pix = 0; vif.mode_in = 0;
    vif.r_in = 0; vif.g_in = 0; vif.b_in = 0;
    vif.hsync_in = 0; vif.vsync_in = 0;
    vif.hblank_in = 0; vif.vblank_in = 0;
    model_clear();
    do_reset(0, 0);

    px("post_rst0", 0, 0, 0, 0);
    px("post_rst1", 0, 0, 0, 0);

    set_mode(2'd3);
    step("bw_white", 63, 63, 63, 1, 0, 0, 0, 3, 1);
    flush("bw_lat", 3);

    set_mode(2'd1);
    px("gr_r", 63, 0, 0, 1);
    px("gr_g", 0, 63, 0, 1);
    px("gr_b", 0, 0, 63, 1);
    flush("gr_out", 1);

    set_mode(2'd2);
    px("amb_w", 63, 63, 63, 2);
    flush("amb_out", 2);

    set_mode(2'd0);
    px("col", 10, 20, 30, 0);
    flush("col_out", 0);

    for (int i = 0; i < 4; i++) px("defer", 10, 20, 30, 3);
    flush("defer_out", 3);
    set_mode(2'd3);
    px("grey", 10, 20, 30, 3);
    flush("grey_out", 3);

    for (int i = 0; i < 8; i++)
      step("ce_tog", 6'(5 * i + 3), 6'(7 * i), 6'(63 - i),
           i[0], 0, 0, 0, 3, ~i[0]);
    flush("ce_out", 3);

    px("rst_a", 40, 50, 60, 3);
    px("rst_b", 20, 10, 5, 3);
    do_reset(1, 2);
    px("rst_z0", 9, 9, 9, 0);
    px("rst_z1", 0, 0, 0, 0);
    flush("rst_z2", 0);

`ifdef VIDEO_MONO_SCANLINE_EN
    set_mode(2'd3);
    step("sl_vs0", 0, 0, 0, 0, 0, 1, 1, 3, 1);
    step("sl_vs1", 0, 0, 0, 1, 1, 1, 1, 3, 1);
    step("sl_vs2", 0, 0, 0, 0, 1, 1, 1, 3, 1);
    step("sl_vs3", 0, 0, 0, 0, 0, 1, 0, 3, 1);
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 4; p++) px("sl_pix", 63, 63, 63, 3);
      step("sl_hb0", 0, 0, 0, 1, 0, 1, 0, 3, 1);
      step("sl_hb1", 0, 0, 0, 0, 0, 1, 0, 3, 1);
    end
    flush("sl_out", 3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
